itype_encoder: RTL
==================

# itype_encoder

- Producer side of the I-type datapath instruction port.
- Accepts decoded instruction fields (operation, rd, rs1, signed immediate) over a valid/ready handshake.
- Encodes each accepted request into a 32-bit RV64 I-type instruction word, buffers it in a small FIFO, and issues it to the datapath over a second valid/ready handshake.
- Reports illegal requests and counts issued instructions.

## Interface

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of issue and error counters.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  request fields valid.
- in_ready  out  1  encoder can accept a request this cycle.
- in_op  in  4  0 ADDI, 1 SLTI, 2 SLTIU, 3 XORI, 4 ORI, 5 ANDI, 6 SLLI, 7 SRLI, 8 SRAI, 9 LD, 10 LW; 11–15 illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register.
- in_imm  in  16  signed immediate, or shift amount.
- out_valid  out  1  out_instr holds a valid word.
- out_ready  in  1  datapath consumes the word.
- out_instr  out  32  encoded instruction (FIFO head).
- err  out  1  one-cycle pulse for a dropped illegal request.
- issued_cnt  out  CNT_W  words consumed by the datapath.
- err_cnt  out  CNT_W  requests dropped.

## Operation

- Input transfer: in_valid && in_ready on a rising edge.
- Output transfer: out_valid && out_ready on a rising edge.
- Encoding: {imm[11:0], rs1, funct3, rd, opcode}.
  - ALU ops use opcode 0010011 with funct3: ADDI 000, SLTI 010, SLTIU 011, XORI 100, ORI 110, ANDI 111.
  - Shift ops:
    - SLLI: funct3 001, imm[11:6] = 000000.
    - SRLI: funct3 101, imm[11:6] = 000000.
    - SRAI: funct3 101, imm[11:6] = 010000.
    - imm[5:0] = in_imm[5:0] for all three.
  - Loads use opcode 0000011: LD funct3 011, LW funct3 010.
- Illegal request:
  - An illegal request still completes its input handshake.
  - No FIFO write occurs.
  - err pulses high for the cycle after acceptance, and err_cnt increments.
- FIFO:
  - Circular buffer with read and write pointers plus an occupancy count of 0..DEPTH.
  - in_ready = (count != DEPTH). There is no write-through when full, even if a pop occurs in the same cycle.
  - out_valid = (count != 0).
  - Simultaneous push and pop leaves count unchanged; both pointers advance and wrap modulo DEPTH.
  - An illegal request combined with a pop acts as a pop only.
- out_instr must stay stable while out_valid && !out_ready.
- issued_cnt increments on each output transfer. Both counters wrap at 2^CNT_W.

## Timing

- Reset (rst = 0 at an edge):
  - count and pointers cleared.
  - out_valid 0, out_instr 0, err 0, issued_cnt 0, err_cnt 0.
  - in_ready 1 from the first cycle after reset.
- Reset asserted mid-operation discards all buffered words at that edge; nothing in flight survives.
- Latency: a request accepted at edge N into an empty FIFO gives out_valid = 1 and the word on out_instr in the cycle after edge N.
- Throughput: one request per cycle and one issue per cycle sustained.
- Full FIFO with out_ready = 1: in_ready stays 0 this cycle and returns to 1 after the pop edge.
- err is registered. It pulses in the cycle after the offending edge and never lasts more than one cycle per illegal request.

## Configuration

The immediate range check is compiled in or out with ITYPE_IMM_CHECK_EN.

- ITYPE_IMM_CHECK_EN defined:
  - Shift ops require in_imm in 0..63.
  - All other ops require in_imm in -2048..2047.
  - An out-of-range request is illegal: dropped, err pulse, err_cnt increments.
- ITYPE_IMM_CHECK_EN undefined:
  - No range check; only illegal in_op values are rejected.
  - in_imm is truncated: low 12 bits, or low 6 bits for shift ops.

## Test plan

- Reset, then ADDI rd=7 rs1=5 imm=53 with out_ready=1 -> out_instr 32'h03528393 one cycle later; issued_cnt 1.
- ADDI rd=15 rs1=7 imm=-5 -> 32'hFFB38793. SRAI rd=1 rs1=2 imm=3 -> 32'h40315093. LD rd=10 rs1=2 imm=8 -> 32'h00813503.
- out_ready=0 and five back-to-back requests -> 4 accepted, in_ready 0 on the fifth; after out_ready=1, words issue in order with pointer wrap and count stays correct.
- in_op=12 -> no FIFO write, err pulses once, err_cnt 1, out_valid unaffected.
- ITYPE_IMM_CHECK_EN defined, ADDI imm=2048 -> dropped, err pulses. Undefined -> word 32'h80000013-style encoding with imm[11:0]=12'h800 is issued.
- rst=0 while 3 words are buffered -> next cycle out_valid 0, counters 0, in_ready 1.

Source files
------------

// File: rtl/itype_encoder.sv
`default_nettype none
// ============================================================================
// Module   : itype_encoder
// Purpose  : Encodes decoded I-type fields into 32-bit RV64 instruction words,
//            buffers them in a DEPTH-entry FIFO and issues them downstream.
//            Optional immediate range check: define ITYPE_IMM_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
module itype_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [15:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] c_full    = (AW+1)'(DEPTH);
  localparam logic [6:0]  c_op_imm  = 7'b0010011;
  localparam logic [6:0]  c_op_load = 7'b0000011;

  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_err;
  logic [CNT_W-1:0] r_issued_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_legal_op;
  logic             w_is_shift;
  logic             w_imm_ok;
  logic [2:0]       w_funct3;
  logic [6:0]       w_opcode;
  logic [11:0]      w_imm12;
  logic [31:0]      w_word;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;

  always_comb begin
    w_legal_op = 1'b1;
    w_is_shift = 1'b0;
    w_funct3   = 3'b000;
    w_opcode   = c_op_imm;
    w_imm12    = in_imm[11:0];
    case (in_op)
      4'd0:  w_funct3 = 3'b000;
      4'd1:  w_funct3 = 3'b010;
      4'd2:  w_funct3 = 3'b011;
      4'd3:  w_funct3 = 3'b100;
      4'd4:  w_funct3 = 3'b110;
      4'd5:  w_funct3 = 3'b111;
      4'd6: begin
        w_is_shift = 1'b1;
        w_funct3   = 3'b001;
        w_imm12    = {6'b000000, in_imm[5:0]};
      end
      4'd7: begin
        w_is_shift = 1'b1;
        w_funct3   = 3'b101;
        w_imm12    = {6'b000000, in_imm[5:0]};
      end
      4'd8: begin
        // SRAI distinguishes itself from SRLI only through imm[10]
        w_is_shift = 1'b1;
        w_funct3   = 3'b101;
        w_imm12    = {6'b010000, in_imm[5:0]};
      end
      4'd9: begin
        w_opcode = c_op_load;
        w_funct3 = 3'b011;
      end
      4'd10: begin
        w_opcode = c_op_load;
        w_funct3 = 3'b010;
      end
      default: w_legal_op = 1'b0;
    endcase
  end

`ifdef ITYPE_IMM_CHECK_EN
  // Shift amounts must be 0..63; others must sign-extend cleanly from bit 11
  assign w_imm_ok = w_is_shift ? (in_imm[15:6] == 10'd0)
                               : ((&in_imm[15:11]) | ~(|in_imm[15:11]));
`else
  logic w_unused_imm;
  assign w_unused_imm = &{1'b0, in_imm[15:12], w_is_shift};
  assign w_imm_ok     = 1'b1;
`endif

  assign w_word    = {w_imm12, in_rs1, w_funct3, in_rd, w_opcode};
  assign in_ready  = (r_count != c_full);
  assign out_valid = (r_count != '0);
  assign w_accept  = in_valid && in_ready;
  assign w_push    = w_accept && w_legal_op && w_imm_ok;
  assign w_drop    = w_accept && !(w_legal_op && w_imm_ok);
  assign w_pop     = out_valid && out_ready;

  assign out_instr  = out_valid ? r_mem[r_rd_ptr] : 32'd0;
  assign err        = r_err;
  assign issued_cnt = r_issued_cnt;
  assign err_cnt    = r_err_cnt;

  // Storage is not reset; out_instr is masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_err        <= 1'b0;
      r_issued_cnt <= '0;
      r_err_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_err <= w_drop;
      if (w_drop) r_err_cnt    <= r_err_cnt + CNT_W'(1);
      if (w_pop)  r_issued_cnt <= r_issued_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
